uart_tx_scheduler: RTL and testbench

- Shares one 8N1 UART transmit line among N_REQ requesters.
- Round-robin arbitration between requesters, one whole frame per grant.
- Bit timing comes from the existing DDS baud generator's `enable_16` tick (16 ticks per bit). This block is the consumer and sequencer of that tick.
- Sits between firmware/command-engine byte sources and the board TX pin.

---
 rtl/uart_tx_scheduler_pkg.sv | 20 ++
 rtl/uart_tx_scheduler_if.sv | 26 ++
 rtl/uart_tx_scheduler_rr_arbiter.sv | 35 +++
 rtl/uart_tx_scheduler.sv | 155 +++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and constants for the round-robin UART transmit scheduler.
package uart_tx_scheduler_pkg;

  localparam int UART_DATA_BITS     = 8;
  localparam int UART_TICKS_DEFAULT = 16;

  // Frame sequencer states.
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // Counter width for a modulo-n count, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Byte-source handshake bundle: one valid/ready pair and one byte lane per requester.
interface uart_tx_scheduler_if
  import uart_tx_scheduler_pkg::*;
#(
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0]                req_valid;
  logic [UART_DATA_BITS*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]                req_ready;

  // Requester side drives bytes and sees the accept pulse.
  modport master (
    output req_valid,
    output req_data,
    input  req_ready
  );

  // Scheduler side accepts bytes.
  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester above i_last, wrapping.
module uart_tx_scheduler_rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [2:0]       i_last,
  output logic [N_REQ-1:0] o_grant,
  output logic [2:0]       o_idx,
  output logic             o_any
);

  // Bit k of a request vector, with a plain integer index.
  function automatic logic req_at(input logic [N_REQ-1:0] v, input int k);
    logic [N_REQ-1:0] s;
    s = v >> k;
    return s[0];
  endfunction

  // Walk from the farthest candidate to the nearest so the nearest set request wins.
  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves one
    // unassigned and no latch is inferred.
    o_idx = 3'd0;
    o_any = 1'b0;
    for (int off = N_REQ; off >= 1; off--) begin
      if (req_at(i_req, (int'(i_last) + off) % N_REQ)) begin
        o_idx = 3'((int'(i_last) + off) % N_REQ);
        o_any = 1'b1;
      end
    end
  end

  assign o_grant = o_any ? (N_REQ'(1) << o_idx) : '0;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one 8N1 transmit line among N_REQ byte sources, one whole frame per grant.
// Bit timing is driven by the baud generator's enable_16 oversample tick.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int STOP_BITS     = 1,
  parameter int TICKS_PER_BIT = UART_TICKS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable_16,
  uart_tx_scheduler_if.slave    req_if,
  output logic                  tx,
  output logic                  busy,
  output logic [2:0]            active_id
);

  localparam int               TW        = cnt_width(TICKS_PER_BIT);
  localparam logic [TW-1:0]    TICK_LAST = TW'(TICKS_PER_BIT - 1);
  localparam logic [3:0]       DATA_LAST = 4'(UART_DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  state_t                      r_state,     w_state_nxt;
  logic [TW-1:0]               r_tick_cnt,  w_tick_nxt;
  logic [3:0]                  r_bit_cnt,   w_bit_nxt;
  logic [UART_DATA_BITS-1:0]   r_shreg,     w_shreg_nxt;
  logic                        r_tx,        w_tx_nxt;
  logic                        r_busy,      w_busy_nxt;
  logic [2:0]                  r_active_id, w_active_nxt;
  logic [2:0]                  r_rr_last,   w_rr_nxt;

  logic [N_REQ-1:0]                w_grant;
  logic [2:0]                      w_grant_idx;
  logic                            w_grant_any;
  logic [N_REQ-1:0]                w_ready;
  logic [UART_DATA_BITS*N_REQ-1:0] w_data_sh;
  logic [UART_DATA_BITS-1:0]       w_grant_byte;
  logic                            w_bit_done;

  uart_tx_scheduler_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .i_req   (req_if.req_valid),
    .i_last  (r_rr_last),
    .o_grant (w_grant),
    .o_idx   (w_grant_idx),
    .o_any   (w_grant_any)
  );

  // Byte lane of the winning requester.
  assign w_data_sh    = req_if.req_data >> {w_grant_idx, 3'b000};
  assign w_grant_byte = w_data_sh[UART_DATA_BITS-1:0];

  // A qualifying tick closes the current bit period.
  assign w_bit_done = enable_16 && (r_tick_cnt == TICK_LAST);

  // Next-state and registered-output decode for the frame sequencer.
  always_comb begin
    w_state_nxt  = r_state;
    w_tick_nxt   = r_tick_cnt;
    w_bit_nxt    = r_bit_cnt;
    w_shreg_nxt  = r_shreg;
    w_active_nxt = r_active_id;
    w_rr_nxt     = r_rr_last;
    w_ready      = '0;
    w_tx_nxt     = 1'b1;
    w_busy_nxt   = 1'b0;

    unique case (r_state)
      IDLE: begin
        // The grant cycle's enable_16 is deliberately not counted.
        if (w_grant_any) begin
          w_ready      = w_grant;
          w_shreg_nxt  = w_grant_byte;
          w_active_nxt = w_grant_idx;
          w_rr_nxt     = w_grant_idx;
          w_tick_nxt   = '0;
          w_bit_nxt    = 4'd0;
          w_state_nxt  = START;
        end
      end
      START, DATA, STOP: begin
        if (enable_16) begin
          w_tick_nxt = w_bit_done ? '0 : r_tick_cnt + 1'b1;
        end
        if (w_bit_done) begin
          unique case (r_state)
            START: begin
              w_state_nxt = DATA;
              w_bit_nxt   = 4'd0;
            end
            DATA: begin
              if (r_bit_cnt == DATA_LAST) begin
                w_state_nxt = STOP;
                w_bit_nxt   = 4'd0;
              end else begin
                w_shreg_nxt = r_shreg >> 1;
                w_bit_nxt   = r_bit_cnt + 4'd1;
              end
            end
            default: begin
              if (r_bit_cnt == STOP_LAST) begin
                w_state_nxt = IDLE;
                w_bit_nxt   = 4'd0;
              end else begin
                w_bit_nxt   = r_bit_cnt + 4'd1;
              end
            end
          endcase
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Line level follows the state being entered, so tx is a clean flop output.
    unique case (w_state_nxt)
      START: begin w_tx_nxt = 1'b0;           w_busy_nxt = 1'b1; end
      DATA:  begin w_tx_nxt = w_shreg_nxt[0]; w_busy_nxt = 1'b1; end
      STOP:  begin w_tx_nxt = 1'b1;           w_busy_nxt = 1'b1; end
      default: begin w_tx_nxt = 1'b1;         w_busy_nxt = 1'b0; end
    endcase
  end

  // Sequencer registers; reset aborts any frame and returns the line to idle-high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_tick_cnt  <= '0;
      r_bit_cnt   <= 4'd0;
      r_shreg     <= '0;
      r_tx        <= 1'b1;
      r_busy      <= 1'b0;
      r_active_id <= 3'd0;
      r_rr_last   <= 3'(N_REQ - 1);
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values
      // regardless of statement order.
      r_state     <= w_state_nxt;
      r_tick_cnt  <= w_tick_nxt;
      r_bit_cnt   <= w_bit_nxt;
      r_shreg     <= w_shreg_nxt;
      r_tx        <= w_tx_nxt;
      r_busy      <= w_busy_nxt;
      r_active_id <= w_active_nxt;
      r_rr_last   <= w_rr_nxt;
    end
  end

  // The accept pulse is combinational from IDLE; held off while reset is asserted.
  assign req_if.req_ready = reset ? '0 : w_ready;

  assign tx        = r_tx;
  assign busy      = r_busy;
  assign active_id = r_active_id;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: stimulus pushes expected grants and frames,
// a grant monitor and a frame monitor pop and compare as the DUT produces them.
module tb_uart_tx_scheduler;
  import uart_tx_scheduler_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable_16 = 1'b0;
  int   tick_period = 1;

  initial forever #5 clk = ~clk;

  uart_tx_scheduler_if #(.N_REQ(N)) if_a ();
  uart_tx_scheduler_if #(.N_REQ(N)) if_b ();

  logic       tx_a, busy_a, tx_b, busy_b;
  logic [2:0] aid_a, aid_b;

  uart_tx_scheduler #(.N_REQ(N), .STOP_BITS(1), .TICKS_PER_BIT(16)) dut_a (
    .clk(clk), .reset(reset), .enable_16(enable_16), .req_if(if_a.slave),
    .tx(tx_a), .busy(busy_a), .active_id(aid_a)
  );

  uart_tx_scheduler #(.N_REQ(N), .STOP_BITS(2), .TICKS_PER_BIT(16)) dut_b (
    .clk(clk), .reset(reset), .enable_16(enable_16), .req_if(if_b.slave),
    .tx(tx_b), .busy(busy_b), .active_id(aid_b)
  );

  // mon_sel picks which DUT the requesters and monitors talk to.
  logic           mon_sel = 1'b0;
  int             mon_stop = 1;
  logic [N-1:0]   drv_valid;
  logic [8*N-1:0] drv_data;

  assign if_a.req_valid = mon_sel ? '0 : drv_valid;
  assign if_b.req_valid = mon_sel ? drv_valid : '0;
  assign if_a.req_data  = drv_data;
  assign if_b.req_data  = drv_data;

  logic         m_tx, m_busy;
  logic [2:0]   m_aid;
  logic [N-1:0] m_ready;
  assign m_tx    = mon_sel ? tx_b   : tx_a;
  assign m_busy  = mon_sel ? busy_b : busy_a;
  assign m_aid   = mon_sel ? aid_b  : aid_a;
  assign m_ready = mon_sel ? if_b.req_ready : if_a.req_ready;

  typedef struct {
    int id;
    int data;
    int clks;   // expected busy length in clocks
    int tol;    // allowed deviation, negative = not checked
    int gap;    // expected idle clocks before frame, negative = not checked
  } exp_frame_t;

  exp_frame_t exp_frame_q[$];
  int         exp_grant_q[$];
  logic [7:0] src_q[N][$];

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Queue a byte on requester id together with its expected grant and frame.
  task automatic send(input int id, input int data, input int clks, input int tol, input int gap);
    exp_frame_t e;
    e = '{id, data, clks, tol, gap};
    src_q[id].push_back(8'(data));
    exp_grant_q.push_back(id);
    exp_frame_q.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_frame_q.size() != 0 || exp_grant_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain_timeout"}, int'(n >= budget), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_busy(input string name);
    int n;
    n = 0;
    while (!m_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_busy_timeout"}, int'(n >= 100), 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_tx_a", tx_a, 1);
    check("rst_busy_a", busy_a, 0);
    check("rst_ready_a", int'(if_a.req_ready), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  // Oversample tick: every cycle (1), never (0), or every tick_period cycles.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      cnt++;
      if (tick_period == 1)      enable_16 = 1'b1;
      else if (tick_period <= 0) enable_16 = 1'b0;
      else                       enable_16 = (cnt % tick_period == 0);
    end
  end

  // Requester model and grant monitor: hold each byte until accepted.
  initial begin
    logic [N-1:0] hs;
    int gid;
    drv_valid = '0;
    drv_data  = '0;
    forever begin
      @(negedge clk);
      hs = drv_valid & m_ready;
      if (m_ready != '0) begin
        gid = 0;
        for (int i = 0; i < N; i++) if (m_ready[i]) gid = i;
        check("ready_onehot", int'($onehot(m_ready)), 1);
        check("ready_without_valid", int'(m_ready & ~drv_valid), 0);
        if (exp_grant_q.size() == 0) check("grant_unexpected", gid, -1);
        else                         check("grant_id", gid, exp_grant_q.pop_front());
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        drv_valid[i]      = (src_q[i].size() > 0);
        drv_data[8*i +: 8] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
      end
    end
  end

  // Frame monitor: samples each bit at its mid-tick, counting enable_16 pulses.
  initial begin
    int         idle_cnt, gap, aid, ticks, clks, last_b, nbits, act;
    logic [10:0] rx;
    logic        aborted;
    exp_frame_t  e;
    idle_cnt = 0;
    forever begin
      @(negedge clk);
      if (reset || !m_busy) begin
        idle_cnt++;
        continue;
      end
      gap      = idle_cnt;
      idle_cnt = 0;
      aid      = int'(m_aid);
      ticks    = 0;
      clks     = 1;
      last_b   = -1;
      rx       = '0;
      aborted  = 1'b0;
      nbits    = 9 + mon_stop;
      check("start_edge", m_tx, 0);
      forever begin
        @(posedge clk);
        if (enable_16) ticks++;
        @(negedge clk);
        if (reset) begin aborted = 1'b1; break; end
        if (!m_busy) break;
        clks++;
        if (ticks % 16 == 8 && ticks / 16 != last_b && ticks / 16 < 11) begin
          last_b     = ticks / 16;
          rx[last_b] = m_tx;
        end
        if (clks > 20000) begin
          check("frame_timeout", clks, 0);
          aborted = 1'b1;
          break;
        end
      end
      if (aborted) begin
        idle_cnt = 0;
        continue;
      end
      idle_cnt = 1;
      check("frame_ticks", ticks, 16 * nbits);
      check("frame_start_bit", rx[0], 0);
      check("frame_stop1", rx[9], 1);
      if (nbits == 11) check("frame_stop2", rx[10], 1);
      if (exp_frame_q.size() == 0) begin
        check("frame_unexpected", aid, -1);
      end else begin
        e = exp_frame_q.pop_front();
        check("frame_id", aid, e.id);
        check("frame_data", int'(rx[8:1]), e.data);
        if (e.tol >= 0) begin
          act = ((clks >= e.clks - e.tol) && (clks <= e.clks + e.tol)) ? e.clks : clks;
          check("frame_clks", act, e.clks);
        end
        if (e.gap >= 0) check("frame_gap", gap, e.gap);
      end
    end
  end

  // Directed scenarios.
  initial begin
    logic tx0, changed;

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_tx", tx_a, 1);
    check("reset_busy", busy_a, 0);
    check("reset_ready", int'(if_a.req_ready), 0);
    check("reset_active_id", int'(aid_a), 0);
    check("reset_tx_b", tx_b, 1);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte 0x55, tick every clock: 160 busy clocks.
    tick_period = 1;
    send(0, 8'h55, 160, 0, -1);
    wait_drain("single", 400);
    check("active_id_hold", int'(aid_a), 0);

    // Round-robin from a fresh reset: 0,1,2,3,0 back-to-back with 1-cycle gaps.
    pulse_reset();
    send(0, 8'hA0, 160, 0, -1);
    send(1, 8'hA1, 160, 0, 1);
    send(2, 8'hA2, 160, 0, 1);
    send(3, 8'hA3, 160, 0, 1);
    send(0, 8'hA4, 160, 0, 1);
    wait_drain("rr", 1200);

    // Sparse tick every 7 clocks, byte 0xFF: 1120 clocks +/-7.
    tick_period = 7;
    send(2, 8'hFF, 1120, 7, -1);
    wait_drain("sparse", 1500);
    tick_period = 1;
    repeat (3) @(negedge clk);

    // Stall mid-DATA for 1000 clocks; byte 0x3C, stalls inside data bit 3 (=1).
    send(3, 8'h3C, 0, -1, -1);
    wait_busy("stall");
    repeat (69) @(negedge clk);
    tick_period = 0;
    repeat (3) @(negedge clk);
    tx0 = tx_a;
    check("stall_tx_bit", tx0, 1);
    changed = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx_a !== tx0 || busy_a !== 1'b1) changed = 1'b1;
    end
    check("stall_stable", changed, 0);
    tick_period = 1;
    wait_drain("stall", 400);

    // Two stop bits on the second instance, byte 0x00: 176 busy clocks.
    mon_sel  = 1'b1;
    mon_stop = 2;
    send(0, 8'h00, 176, 0, -1);
    wait_drain("stop2", 400);
    mon_sel  = 1'b0;
    mon_stop = 1;
    repeat (3) @(negedge clk);

    // Reset during data bit 3 of a frame from requester 2 (0x96, bit 3 = 0).
    src_q[2].push_back(8'h96);
    exp_grant_q.push_back(2);
    wait_busy("midrst");
    repeat (16 * 4 + 8) @(negedge clk);
    check("pre_reset_tx", tx_a, 0);
    #2 reset = 1'b1;
    #1;
    check("midrst_tx", tx_a, 1);
    check("midrst_busy", busy_a, 0);
    check("midrst_ready", int'(if_a.req_ready), 0);
    send(1, 8'h11, 160, 0, -1);
    send(2, 8'h22, 160, 0, 1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_drain("midrst", 800);
    check("midrst_last_id", int'(aid_a), 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Last-resort guard against a hang.
  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1);
  end

endmodule
